// File: rtl/mips_pkg.sv
// Shared opcodes, functs, field widths, FSM and ALU encodings for the multi-cycle MIPS core.
// Combinational helpers only; no latency or flow control of their own.
package mips_pkg;

  localparam int OPCODE_W = 6;
  localparam int REGF_W   = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int JADDR_W  = 26;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op, input logic [FUNCT_W-1:0] fn);
    logic v;
    v = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: v = 1'b1;
          default: v = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Branches compare through SUB so the ALU zero flag decides taken/not-taken.
  function automatic alu_op_t alu_sel(input logic [OPCODE_W-1:0] op, input logic [FUNCT_W-1:0] fn);
    alu_op_t s;
    s = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  s = ALU_SUB;
        FN_AND:  s = ALU_AND;
        FN_OR:   s = ALU_OR;
        FN_SLT:  s = ALU_SLT;
        FN_SLL:  s = ALU_SLL;
        FN_SRL:  s = ALU_SRL;
        default: s = ALU_ADD;
      endcase
    end else if (op == OP_BEQ || op == OP_BNE) begin
      s = ALU_SUB;
    end
    return s;
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: zero latency, no flow control. Shifts operate on i_b by i_shamt.
module mc_alu
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]    i_a,
  input  logic [XLEN-1:0]    i_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  alu_op_t            i_op,
  output logic [XLEN-1:0]    o_result,
  output logic               o_zero
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLL: o_result = i_b << i_shamt;
      ALU_SRL: o_result = i_b >> i_shamt;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core on one shared word memory port; R/addi 4, lw 5, sw 4, branch/j 3 cycles.
// Each memory access holds req/addr/we/wdata until mem_ready, adding one cycle per wait state.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               NREGS    = 32,
  parameter int               ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_alu_out;
  logic [XLEN-1:0]   r_mdr;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic              r_retire;
  logic              r_halted;
  logic [XLEN-1:0]   r_regs [NREGS];

  logic [OPCODE_W-1:0] w_op;
  logic [FUNCT_W-1:0]  w_funct;
  logic [REGF_W-1:0]   w_rs;
  logic [REGF_W-1:0]   w_rt;
  logic [REGF_W-1:0]   w_rd;
  logic [RIDX_W-1:0]   w_rs_i;
  logic [RIDX_W-1:0]   w_rt_i;
  logic [RIDX_W-1:0]   w_dest_i;
  logic [XLEN-1:0]     w_imm_ext;
  logic                w_is_r;
  logic                w_use_b;
  logic [XLEN-1:0]     w_alu_b;
  alu_op_t             w_alu_op;
  logic [XLEN-1:0]     w_alu_res;
  logic                w_alu_zero;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_br_tgt;
  logic [ADDR_W-1:0]   w_jtgt;
  logic [XLEN-1:0]     w_wb_data;

  always_comb begin
    w_op      = r_ir[31:26];
    w_rs      = r_ir[25:21];
    w_rt      = r_ir[20:16];
    w_rd      = r_ir[15:11];
    w_funct   = r_ir[5:0];
    w_rs_i    = w_rs[RIDX_W-1:0];
    w_rt_i    = w_rt[RIDX_W-1:0];
    w_is_r    = (w_op == OP_RTYPE);
    w_dest_i  = w_is_r ? w_rd[RIDX_W-1:0] : w_rt_i;
    w_imm_ext = {{(XLEN-IMM_W){r_ir[15]}}, r_ir[15:0]};
    w_use_b   = w_is_r || (w_op == OP_BEQ) || (w_op == OP_BNE);
    w_alu_b   = w_use_b ? r_b : w_imm_ext;
    w_alu_op  = alu_sel(w_op, w_funct);
    w_taken   = (w_op == OP_BEQ) ? w_alu_zero : !w_alu_zero;
    // r_pc already points past the branch, so the offset is relative to pc+1.
    w_br_tgt  = r_pc + w_imm_ext[ADDR_W-1:0];
    w_jtgt    = r_ir[ADDR_W-1:0];
    w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu_out;
  end

  mc_alu #(.XLEN(XLEN)) u_alu (
    .i_a      (r_a),
    .i_b      (w_alu_b),
    .i_shamt  (r_ir[10:6]),
    .i_op     (w_alu_op),
    .o_result (w_alu_res),
    .o_zero   (w_alu_zero)
  );

  // Memory request signals are registered a state ahead, so they are stable for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu_out   <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_retire    <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        FETCH: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (mem_ready) begin
            r_ir      <= mem_rdata[31:0];
            r_pc      <= r_pc + 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= DECODE;
          end
        end
        DECODE: begin
          r_a <= (w_rs_i == '0) ? '0 : r_regs[w_rs_i];
          r_b <= (w_rt_i == '0) ? '0 : r_regs[w_rt_i];
          if (!is_legal(w_op, w_funct)) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          case (w_op)
            OP_LW, OP_SW: begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= (w_op == OP_SW);
              r_mem_addr  <= w_alu_res[ADDR_W-1:0];
              r_mem_wdata <= r_b;
              r_state     <= MEM;
            end
            OP_BEQ, OP_BNE: begin
              if (w_taken) begin
                r_pc       <= w_br_tgt;
                r_mem_addr <= w_br_tgt;
              end else begin
                r_mem_addr <= r_pc;
              end
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
              r_retire  <= 1'b1;
              r_state   <= FETCH;
            end
            OP_J: begin
              r_pc       <= w_jtgt;
              r_mem_addr <= w_jtgt;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_retire   <= 1'b1;
              r_state    <= FETCH;
            end
            default: begin
              r_alu_out <= w_alu_res;
              r_state   <= WB;
            end
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (r_mem_we) begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_pc;
              r_retire   <= 1'b1;
              r_state    <= FETCH;
            end else begin
              r_mdr     <= mem_rdata;
              r_mem_req <= 1'b0;
              r_state   <= WB;
            end
          end
        end
        WB: begin
          if (w_dest_i != '0) r_regs[w_dest_i] <= w_wb_data;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
          r_retire   <= 1'b1;
          r_state    <= FETCH;
        end
        HALT: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
          r_state   <= HALT;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign retire    = r_retire;
  assign halted    = r_halted;
  assign pc        = r_pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: directed programs push expected memory accesses and retire intervals;
// a negedge monitor models the memory, pops expectations and compares.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        retire;
  logic        halted;
  logic [11:0] pc;

  mips_multicycle_core #(.XLEN(32), .NREGS(32), .ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retire    (retire),
    .halted    (halted),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
  } acc_t;

  // Stimulus-side state (written only by the initial block)
  acc_t        exp_acc [256];
  int          exp_lat [256];
  int          exp_n   = 0;
  int          lat_n   = 0;
  int          prog_id = 0;
  int          waits   = 0;
  bit          first   = 1'b1;
  logic [31:0] prog [4096];

  // Monitor-side state
  int          checks = 0;
  int          errors = 0;
  int          acc_rd = 0;
  int          lat_rd = 0;
  int          seen_id = 0;
  int          wcnt = 0;
  int          last_hs = 0;
  int          last_ret = 0;
  int          run_cyc = 0;
  bit          have_ret = 1'b0;
  bit          halted_q = 1'b0;
  bit          to_flag = 1'b0;
  logic        s_we;
  logic [11:0] s_addr;
  logic [31:0] s_wd;
  logic [31:0] dmem [int];

  always @(negedge clk) begin
    if (seen_id != prog_id) begin
      seen_id = prog_id;
      acc_rd  = 0;
      lat_rd  = 0;
    end
    if (rst) begin
      checks++;
      if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0 || pc !== 12'h000) begin
        errors++;
        $display("FAIL reset_state: req=%b retire=%b halted=%b pc=%h, expected 0 0 0 000",
                 mem_req, retire, halted, pc);
      end
      mem_ready = 1'b0;
      mem_rdata = '0;
      wcnt      = 0;
      have_ret  = 1'b0;
      halted_q  = 1'b0;
      run_cyc   = 0;
      to_flag   = 1'b0;
      dmem.delete();
    end else begin
      mem_ready = 1'b0;
      if (mem_req === 1'b1) begin
        if (wcnt > 0) begin
          checks++;
          if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wd) begin
            errors++;
            $display("FAIL stable_during_wait: addr=%h we=%b wd=%h, expected addr=%h we=%b wd=%h",
                     mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wd);
          end
        end
        s_addr = mem_addr;
        s_we   = mem_we;
        s_wd   = mem_wdata;
        if (wcnt >= waits) begin
          mem_ready = 1'b1;
          mem_rdata = dmem.exists(int'(mem_addr)) ? dmem[int'(mem_addr)] : prog[mem_addr];
          if (mem_we) dmem[int'(mem_addr)] = mem_wdata;
          last_hs = cyc;
          wcnt    = 0;
          checks++;
          if (acc_rd >= exp_n) begin
            errors++;
            $display("FAIL access_unexpected: we=%b addr=%h wd=%h, expected no access", mem_we, mem_addr, mem_wdata);
          end else begin
            if (mem_we !== exp_acc[acc_rd].we || mem_addr !== exp_acc[acc_rd].addr ||
                (exp_acc[acc_rd].we && mem_wdata !== exp_acc[acc_rd].wd)) begin
              errors++;
              $display("FAIL access[%0d]: we=%b addr=%h wd=%h, expected we=%b addr=%h wd=%h", acc_rd,
                       mem_we, mem_addr, mem_wdata, exp_acc[acc_rd].we, exp_acc[acc_rd].addr, exp_acc[acc_rd].wd);
            end
            acc_rd++;
          end
        end else begin
          wcnt++;
        end
      end
      if (retire === 1'b1) begin
        if (have_ret) begin
          checks++;
          if (lat_rd >= lat_n) begin
            errors++;
            $display("FAIL retire_unexpected: interval=%0d, expected no retire", cyc - last_ret);
          end else begin
            if (cyc - last_ret != exp_lat[lat_rd]) begin
              errors++;
              $display("FAIL retire_interval[%0d]: got %0d cycles, expected %0d", lat_rd, cyc - last_ret, exp_lat[lat_rd]);
            end
            lat_rd++;
          end
        end
        have_ret = 1'b1;
        last_ret = cyc;
      end
      if (halted === 1'b1) begin
        if (!halted_q) begin
          checks++;
          if (cyc - last_hs != 2) begin
            errors++;
            $display("FAIL halt_delay: got %0d cycles after last fetch, expected 2", cyc - last_hs);
          end
          checks++;
          if (acc_rd != exp_n || lat_rd != lat_n) begin
            errors++;
            $display("FAIL halt_complete: accesses %0d/%0d retires %0d/%0d, expected all consumed",
                     acc_rd, exp_n, lat_rd, lat_n);
          end
        end else begin
          checks++;
          if (mem_req !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL halt_quiet: req=%b retire=%b, expected 0 0", mem_req, retire);
          end
        end
        halted_q = 1'b1;
      end else begin
        run_cyc++;
        if (run_cyc == 2500) begin
          checks++;
          errors++;
          to_flag = 1'b1;
          $display("FAIL halt_timeout: halted=%b after %0d cycles, expected 1", halted, run_cyc);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] a);
    return {6'h02, a};
  endfunction

  task automatic begin_prog(input int w);
    prog_id++;
    exp_n = 0;
    lat_n = 0;
    first = 1'b1;
    waits = w;
    for (int i = 0; i < 4096; i++) prog[i] = 32'hFC00_0000;
  endtask

  task automatic put(input int a, input logic [31:0] word);
    prog[a] = word;
  endtask

  // lat = 0 marks a fetch that must not retire (the illegal instruction)
  task automatic ex(input logic [11:0] a, input int lat);
    exp_acc[exp_n] = '{we: 1'b0, addr: a, wd: 32'h0};
    exp_n++;
    if (lat > 0) begin
      if (!first) begin
        exp_lat[lat_n] = lat;
        lat_n++;
      end
      first = 1'b0;
    end
  endtask

  task automatic st(input logic [11:0] a, input logic [31:0] d);
    exp_acc[exp_n] = '{we: 1'b1, addr: a, wd: d};
    exp_n++;
  endtask

  task automatic ld(input logic [11:0] a);
    exp_acc[exp_n] = '{we: 1'b0, addr: a, wd: 32'h0};
    exp_n++;
  endtask

  task automatic run_to_halt();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted === 1'b1 || to_flag) break;
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ALU + r0 program, first started with wait states and reset mid-FETCH
    begin_prog(6);
    put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(1,  enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(2,  enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    put(3,  enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A));
    put(4,  enc_r(5'd0, 5'd1, 5'd5, 5'd4, 6'h00));
    put(5,  enc_i(6'h2B, 5'd0, 5'd3, 16'h20));
    put(6,  enc_i(6'h2B, 5'd0, 5'd4, 16'h21));
    put(7,  enc_i(6'h2B, 5'd0, 5'd5, 16'h22));
    put(8,  enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    put(9,  enc_r(5'd0, 5'd0, 5'd7, 5'd0, 6'h20));
    put(10, enc_i(6'h2B, 5'd0, 5'd7, 16'h23));
    put(11, enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h22));
    put(12, enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h24));
    put(13, enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h25));
    put(14, enc_r(5'd0, 5'd2, 5'd11, 5'd28, 6'h02));
    put(15, enc_r(5'd1, 5'd2, 5'd12, 5'd0, 6'h2A));
    for (int r = 8; r <= 12; r++) put(8 + r, enc_i(6'h2B, 5'd0, 5'(r), 16'(16'h1C + r)));
    for (int p = 0; p <= 20; p++) begin
      ex(12'(p), 4);
      case (p)
        5:  st(12'h020, 32'd2);
        6:  st(12'h021, 32'd1);
        7:  st(12'h022, 32'd80);
        10: st(12'h023, 32'd0);
        16: st(12'h024, 32'd8);
        17: st(12'h025, 32'd5);
        18: st(12'h026, 32'hFFFF_FFFD);
        19: st(12'h027, 32'h0000_000F);
        20: st(12'h028, 32'd0);
        default: ;
      endcase
    end
    ex(12'd21, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 waits = 0;
    run_to_halt();

    // Store/load with 3 wait states per access
    begin_prog(3);
    put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(1, enc_i(6'h2B, 5'd0, 5'd1, 16'h10));
    put(2, enc_i(6'h23, 5'd0, 5'd6, 16'h10));
    put(3, enc_i(6'h2B, 5'd0, 5'd6, 16'h11));
    ex(12'd0, 7);
    ex(12'd1, 10); st(12'h010, 32'd5);
    ex(12'd2, 11); ld(12'h010);
    ex(12'd3, 10); st(12'h011, 32'd5);
    ex(12'd4, 0);
    run_to_halt();

    // Branches, jumps and PC wrap
    begin_prog(0);
    put(0,      enc_i(6'h05, 5'd2, 5'd0, 16'd9));
    put(1,      enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    put(2,      enc_j(26'd4));
    put(4,      enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    put(7,      enc_i(6'h05, 5'd1, 5'd1, 16'd2));
    put(8,      enc_j(26'h3FF));
    put(12'h3FF, enc_j(26'hFFF));
    put(12'hFFF, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
    put(10,     enc_i(6'h2B, 5'd0, 5'd2, 16'h30));
    ex(12'd0, 3); ex(12'd1, 4); ex(12'd2, 3); ex(12'd4, 3); ex(12'd7, 3); ex(12'd8, 3);
    ex(12'h3FF, 3); ex(12'hFFF, 4); ex(12'd0, 3);
    ex(12'd10, 4); st(12'h030, 32'd7);
    ex(12'd11, 0);
    run_to_halt();

    // Unknown R-type funct halts, one wait state
    begin_prog(1);
    put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(1, enc_r(5'd1, 5'd1, 5'd2, 5'd0, 6'h3F));
    ex(12'd0, 5);
    ex(12'd1, 0);
    run_to_halt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle MIPS-subset core, successor to the single-cycle cpu.
- Shares one word-addressed memory port for instruction fetch and data, using a req/ready handshake that tolerates wait states.
- Adds reset, halt-on-illegal, bne/addi/slt, a hardwired-zero r0 and a retire strobe.
- Sits between top-level memory (RAM model or bus bridge) and the debug/trace logic.

Parameters:
- XLEN, 32, datapath and register width (≥16).
- NREGS, 32, register count (power of two, ≤32); index = instruction field mod NREGS.
- ADDR_W, 12, word-address width of the memory port.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data, valid in the ready cycle.
- mem_ready  in  1  transaction completes in the cycle where mem_req & mem_ready.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; core stopped on illegal opcode.
- pc  out  ADDR_W  current PC.

Behaviour:
- Instruction fields:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
  - imm [15:0], sign-extended to XLEN; jaddr [25:0].
- Supported ops:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
  - Arithmetic wraps modulo 2^XLEN; no overflow trap.
  - Unknown opcode or unknown R-type funct is illegal.
- Reset (async, any state, including mid-transaction):
  - pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, retire=0, halted=0, all registers 0.
  - A pending memory transaction is abandoned.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until ready; latch IR=mem_rdata, pc<=pc+1 (wraps at 2^ADDR_W) -> DECODE.
  - DECODE: A<=reg[rs], B<=reg[rt]. Illegal -> HALT, else -> EXEC.
  - EXEC, R-type/addi: compute ALU result -> WB.
  - EXEC, lw/sw: eff = (A+sext(imm))[ADDR_W-1:0] -> MEM.
  - EXEC, beq/bne: if taken, pc<=pc+sext(imm) (pc already incremented); retire -> FETCH.
  - EXEC, j: pc<=jaddr[ADDR_W-1:0]; retire -> FETCH.
  - MEM: mem_req=1, mem_addr=eff, mem_we=is_sw, mem_wdata=B. Hold until ready.
    - sw: retire -> FETCH.
    - lw: latch MDR -> WB.
  - WB: write ALU result (R: rd; addi: rt) or MDR (lw: rt); retire -> FETCH.
  - HALT: mem_req=0, halted=1; leave only by reset.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req=0 outside FETCH and MEM.
  - mem_ready is ignored when mem_req=0.
- Register file:
  - Writes to index 0 are discarded; reads of r0 return 0.
  - The write in WB is visible to the next DECODE.
- Latency with zero wait states: R/addi 4 cycles, lw 5, sw 4, beq/bne/j 3.
  - Each wait cycle adds 1 per memory access.
- retire is registered and asserted for exactly one cycle per completed instruction; it is never asserted in HALT.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - FSM state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - field-extraction widths.
- Sub-module mc_alu: combinational, inputs a, b, shamt, op-select; outputs result and zero.
- Register file and FSM stay inline.

Test Plan:
- Reset and first fetch: assert rst mid-FETCH with mem_ready=0 -> mem_req=0, pc=0, halted=0. After release, first request has mem_addr=0, mem_we=0.
- ALU sequence, zero wait:
  - addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sll r5,r1,4.
  - Expect r3=2, r4=1, r5=80, retire every 4 cycles.
- Memory with waits: sw r1 to addr 0x10 (imm=0x10, rs=r0), lw r6 from 0x10, memory ready after 3 wait cycles.
  - mem_addr/mem_wdata stable while waiting; mem_wdata=5.
  - r6=5; lw takes 5+3+3 cycles.
- Branches:
  - beq r1,r1,+2 at pc 4 -> next fetch at 7.
  - bne r1,r1,+2 at pc 4 -> next fetch at 5.
  - j 0x3FF -> next fetch at 0x3FF.
  - PC wrap: instruction fetched at 0xFFF -> next fetch at 0.
- r0 and illegal opcode:
  - addi r0,r0,9 then add r7,r0,r0 -> r7=0.
  - Opcode 0x3F -> halted=1 two cycles after fetch completes; no further mem_req or retire until rst.
